// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, captures instr_mem data into a
// small {pc, instr} FIFO and hands entries to decode over valid/ready.
// Redirects from execute flush the FIFO; misaligned targets halt fetch.
//
// state | meaning
// BOOT  | first cycle after reset release, nothing fetched yet
// FETCH | fetching sequentially, pushing into the buffer when room
// HALT  | stopped on a misaligned redirect, waiting for an aligned one
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  misalign_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] buf_pc    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] buf_instr [FIFO_DEPTH];
  logic                  pop, push, misaligned;

  assign misaligned = |redirect_pc[1:0];
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full buffer can still accept.
  assign push       = (state == FETCH) & ~redirect_valid &
                      ((count < CNT_W'(FIFO_DEPTH)) | pop);
  assign instr_addr = fetch_pc;
  assign out_pc     = buf_pc[rd_ptr];
  assign out_instr  = buf_instr[rd_ptr];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next state: a redirect wins in every state; BOOT only lasts one edge.
  always_comb begin
    state_nxt = state;
    if (redirect_valid)     state_nxt = misaligned ? HALT : FETCH;
    else if (state == BOOT) state_nxt = FETCH;
  end

  // Fetch PC, buffer pointers, occupancy and the misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      // Any same-cycle pop was already taken by decode; the rest is dropped.
      fetch_pc     <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= misaligned;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Buffer storage, written at the tail on every push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (push) begin
      buf_pc[wr_ptr]    <= fetch_pc;
      buf_instr[wr_ptr] <= instr;
    end
  end

endmodule
